// File: rtl/mat_acc_pkg.sv
// Shared types and default sizing for the matrix operand loader.
package mat_acc_pkg;
  localparam int DEPTH_DEF = 256;
  localparam int CNT_W_DEF = 9;

  typedef logic [3:0][7:0] word_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_A    = 3'd1,
    LOAD_B    = 3'd2,
    START     = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;
endpackage

// File: rtl/mat_bank.sv
// DEPTH-word operand register bank with a single write port and synchronous clear.
module mat_bank
  import mat_acc_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [CNT_W-1:0] idx,
  input  logic [3:0][7:0]  data,
  output logic [3:0][7:0]  words [DEPTH]
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDX_W-1:0] addr_s;

  // The loader never drives an index at or beyond DEPTH, so the low bits suffice.
  assign addr_s = idx[IDX_W-1:0];

  // Clear-or-write storage for every bank entry.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        words[i] <= '0;
      end
    end else if (we) begin
      words[addr_s] <= data;
    end
  end
endmodule

// File: rtl/mat_loader.sv
// Streams two operand matrices into register banks, checks in_last framing,
// then hands off to the multiplier and raises irq on completion.
module mat_loader
  import mat_acc_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cfg_words,
  input  logic             go,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic [3:0][7:0]  mat_A [DEPTH],
  output logic [3:0][7:0]  mat_B [DEPTH],
  output logic             mul_start,
  input  logic             mul_done,
  output logic             busy,
  output logic             err,
  output logic             irq
);
  localparam logic [CNT_W-1:0] DEPTH_W = CNT_W'(DEPTH);

  state_t           state_r;
  logic [CNT_W-1:0] idx_r;
  logic [CNT_W-1:0] n_words_r;
  logic [CNT_W-1:0] eff_words_s;
  logic             xfer_s;
  logic             final_s;
  logic             we_a_s;
  logic             we_b_s;

  // Zero or oversize word counts fall back to a full bank.
  always_comb begin
    eff_words_s = cfg_words;
    if ((cfg_words == '0) || (cfg_words > DEPTH_W)) begin
      eff_words_s = DEPTH_W;
    end else begin
      eff_words_s = cfg_words;
    end
  end

  assign xfer_s  = in_valid && in_ready;
  assign final_s = (idx_r == (n_words_r - CNT_W'(1)));
  assign we_a_s  = xfer_s && (state_r == LOAD_A);
  assign we_b_s  = xfer_s && (state_r == LOAD_B);

  // Transaction sequencer; all handshake and status outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      n_words_r <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      mul_start <= 1'b0;
      irq       <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      irq       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (go) begin
            state_r   <= LOAD_A;
            n_words_r <= eff_words_s;
            idx_r     <= '0;
            err       <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LOAD_A, LOAD_B: begin
          if (xfer_s) begin
            // in_last must coincide exactly with the final word of each matrix.
            if (in_last != final_s) begin
              state_r  <= IDLE;
              idx_r    <= '0;
              err      <= 1'b1;
              in_ready <= 1'b0;
              busy     <= 1'b0;
            end else if (final_s) begin
              idx_r <= '0;
              if (state_r == LOAD_A) begin
                state_r <= LOAD_B;
              end else begin
                state_r   <= START;
                in_ready  <= 1'b0;
                mul_start <= 1'b1;
              end
            end else begin
              idx_r <= idx_r + CNT_W'(1);
            end
          end
        end
        START: begin
          state_r <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (mul_done) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            irq     <= 1'b1;
          end
        end
        default: begin
          state_r  <= IDLE;
          idx_r    <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  mat_bank #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_bank_a (
    .clk   (clk),
    .clr   (rst),
    .we    (we_a_s),
    .idx   (idx_r),
    .data  (in_data),
    .words (mat_A)
  );

  mat_bank #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_bank_b (
    .clk   (clk),
    .clr   (rst),
    .we    (we_b_s),
    .idx   (idx_r),
    .data  (in_data),
    .words (mat_B)
  );
endmodule

// File: tb/tb_mat_loader.sv
// Randomized self-checking bench for mat_loader against a word-level transaction model.
module tb_mat_loader;
  localparam int DEPTH = 256;
  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] cfg_words;
  logic             go;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic [3:0][7:0]  mat_A [DEPTH];
  logic [3:0][7:0]  mat_B [DEPTH];
  logic             mul_start;
  logic             mul_done;
  logic             busy;
  logic             err;
  logic             irq;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_a [DEPTH];
  logic [31:0] exp_b [DEPTH];

  mat_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_words (cfg_words),
    .go        (go),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .mat_A     (mat_A),
    .mat_B     (mat_B),
    .mul_start (mul_start),
    .mul_done  (mul_done),
    .busy      (busy),
    .err       (err),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int mm;
    rst = 1'b1; go = 1'b0; in_valid = 1'b0; in_last = 1'b0; mul_done = 1'b0;
    in_data = '0; cfg_words = '0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_a[i] = '0;
      exp_b[i] = '0;
    end
    n_cmp++;
    if ({busy, in_ready, mul_start, irq, err} !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected 00000", {busy, in_ready, mul_start, irq, err});
    end
    mm = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mat_A[i] !== exp_a[i] || mat_B[i] !== exp_b[i]) mm++;
    end
    n_cmp++;
    if (mm != 0) begin
      n_bad++;
      $display("FAIL reset_banks: %0d nonzero words, expected 0", mm);
    end
  endtask

  // One full transaction: bad_pos >= 0 flips the framing flag of that stream word.
  task automatic run_txn(input string name, input int cfg, input int bad_pos, input bit gap,
                         input bit noise, input int done_dly, input bit rst_in_wait);
    int n, last_k, bad_rdy, mm;
    logic flag;
    logic [31:0] d;
    n = (cfg == 0 || cfg > DEPTH) ? DEPTH : cfg;
    last_k = (bad_pos >= 0) ? bad_pos : 2 * n - 1;
    cfg_words = CNT_W'(cfg);
    go = 1'b1;
    tick();
    go = 1'b0;
    n_cmp++;
    if ({busy, in_ready, err} !== 3'b110) begin
      n_bad++;
      $display("FAIL %s go_latency: got busy/ready/err %b expected 110", name, {busy, in_ready, err});
    end
    bad_rdy = 0;
    for (int k = 0; k <= last_k; k++) begin
      go = 1'b0;
      mul_done = 1'b0;
      if (gap) begin
        in_valid = 1'b0;
        if (in_ready !== 1'b1) bad_rdy++;
        tick();
      end
      d = $urandom;
      flag = (k == n - 1) || (k == 2 * n - 1);
      if (k == bad_pos) flag = ~flag;
      in_valid = 1'b1;
      in_data = d;
      in_last = flag;
      if (noise) begin
        mul_done = (k < n) && (k % 3 == 0);
        go = (k >= n);
        if (k >= n) cfg_words = CNT_W'(1);
      end
      if (in_ready !== 1'b1) bad_rdy++;
      if (k < n) exp_a[k] = d;
      else exp_b[k - n] = d;
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; go = 1'b0; mul_done = 1'b0;
    n_cmp++;
    if (bad_rdy != 0) begin
      n_bad++;
      $display("FAIL %s stream_ready: %0d words without in_ready, expected 0", name, bad_rdy);
    end
    if (bad_pos >= 0) begin
      n_cmp++;
      if ({err, busy, in_ready, mul_start} !== 4'b1000) begin
        n_bad++;
        $display("FAIL %s framing_abort: got err/busy/ready/start %b expected 1000", name,
                 {err, busy, in_ready, mul_start});
      end
      mm = 0;
      for (int c = 0; c < 4; c++) begin
        if (mul_start !== 1'b0 || busy !== 1'b0) mm++;
        tick();
      end
      n_cmp++;
      if (mm != 0) begin
        n_bad++;
        $display("FAIL %s abort_quiet: %0d active cycles, expected 0", name, mm);
      end
    end else begin
      n_cmp++;
      if ({mul_start, busy, in_ready, err} !== 4'b1100) begin
        n_bad++;
        $display("FAIL %s start_pulse: got start/busy/ready/err %b expected 1100", name,
                 {mul_start, busy, in_ready, err});
      end
      tick();
      n_cmp++;
      if ({mul_start, busy, in_ready} !== 3'b010) begin
        n_bad++;
        $display("FAIL %s wait_done: got start/busy/ready %b expected 010", name,
                 {mul_start, busy, in_ready});
      end
      for (int c = 1; c < done_dly; c++) tick();
      if (rst_in_wait) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          exp_a[i] = '0;
          exp_b[i] = '0;
        end
        n_cmp++;
        if ({irq, busy, in_ready, mul_start, err} !== 5'b00000) begin
          n_bad++;
          $display("FAIL %s rst_then_done: got %b expected 00000", name,
                   {irq, busy, in_ready, mul_start, err});
        end
        tick();
        n_cmp++;
        if ({irq, busy} !== 2'b00) begin
          n_bad++;
          $display("FAIL %s rst_idle: got irq/busy %b expected 00", name, {irq, busy});
        end
      end else begin
        mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        n_cmp++;
        if ({irq, busy, err} !== 3'b100) begin
          n_bad++;
          $display("FAIL %s irq_pulse: got irq/busy/err %b expected 100", name, {irq, busy, err});
        end
        tick();
        n_cmp++;
        if ({irq, busy} !== 2'b00) begin
          n_bad++;
          $display("FAIL %s irq_single: got irq/busy %b expected 00", name, {irq, busy});
        end
      end
    end
    mm = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mat_A[i] !== exp_a[i] || mat_B[i] !== exp_b[i]) mm++;
    end
    n_cmp++;
    if (mm != 0) begin
      n_bad++;
      $display("FAIL %s bank_contents: %0d wrong words, expected 0", name, mm);
    end
  endtask

  task automatic test_basic();
    run_txn("basic4", 4, -1, 1'b0, 1'b0, 5, 1'b0);
  endtask

  task automatic test_full_depth();
    run_txn("cfg0", 0, -1, 1'b0, 1'b0, 3, 1'b0);
    run_txn("cfg300", 300, -1, 1'b0, 1'b0, 2, 1'b0);
  endtask

  task automatic test_framing();
    run_txn("early_last_a", 4, 1, 1'b0, 1'b0, 1, 1'b0);
    run_txn("missing_last_a", 3, 2, 1'b0, 1'b0, 1, 1'b0);
    run_txn("early_last_b", 4, 5, 1'b0, 1'b0, 1, 1'b0);
    run_txn("after_err", 2, -1, 1'b0, 1'b0, 2, 1'b0);
  endtask

  task automatic test_gapped();
    run_txn("gap2", 2, -1, 1'b1, 1'b0, 2, 1'b0);
  endtask

  task automatic test_noise();
    run_txn("noise", 5, -1, 1'b0, 1'b1, 3, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      run_txn("rand", int'($urandom_range(1, 16)), -1, 1'($urandom_range(0, 1)), 1'b0,
              int'($urandom_range(1, 6)), 1'b0);
    end
  endtask

  task automatic test_rst_in_wait();
    run_txn("rst_wait", 3, -1, 1'b0, 1'b0, 2, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_depth();
    test_framing();
    test_gapped();
    test_noise();
    test_back_to_back();
    test_rst_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mat_loader.md
MAT_LOADER -- requirements
Module: mat_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning 32-bit words per operand bank.
REQ-002 The block SHALL have parameter CNT_W, default 9, meaning width of word counters (holds DEPTH).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cfg_words  input  CNT_W  words per matrix; sampled in IDLE on go; 0 or >DEPTH SHALL be treated as DEPTH.
REQ-006 go  input  1  one-cycle request to begin a load/compute transaction.
REQ-007 in_valid / in_ready / in_data[31:0] / in_last  input/output/input/input  operand stream, each word = four packed 8-bit elements.
REQ-008 mat_A, mat_B  output  DEPTH x [3:0][7:0]  operand banks driven to the multiplier.
REQ-009 mul_start  output  1  start pulse to the multiplier.
REQ-010 mul_done  input  1  completion from the multiplier.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 err  output  1  sticky framing error.
REQ-013 irq  output  1  one-cycle pulse on successful transaction completion.

Function
REQ-014 FSM states SHALL be IDLE, LOAD_A, LOAD_B, START, WAIT_DONE.
REQ-015 IDLE->LOAD_A on go; latch effective cfg_words into n_words; clear word index; clear err.
REQ-016 in_ready SHALL be high only in LOAD_A and LOAD_B; a word transfers when in_valid && in_ready.
REQ-017 LOAD_A: each transfer writes in_data to mat_A[idx], idx increments; on the n_words-th transfer go to LOAD_B with idx=0.
REQ-018 LOAD_B: identical for mat_B; on the n_words-th transfer go to START.
REQ-019 in_last SHALL be required on exactly the final word of each matrix (word n_words-1 of A and of B).
REQ-020 in_last on an earlier word: word is written, err set, FSM returns to IDLE, no mul_start.
REQ-021 Missing in_last on the final word: word is written, err set, FSM returns to IDLE, no mul_start.
REQ-022 START SHALL last exactly one cycle with mul_start=1, then WAIT_DONE; mul_start SHALL be 0 in all other states.
REQ-023 WAIT_DONE->IDLE on mul_done=1, with irq=1 in that cycle; mul_done outside WAIT_DONE SHALL be ignored.
REQ-024 go outside IDLE SHALL be ignored.
REQ-025 Bank entries at index >= n_words SHALL keep their previous contents.
REQ-026 mat_A/mat_B SHALL be stable (no writes) during START and WAIT_DONE.
REQ-027 Latency: go to first in_ready = 1 cycle; last B transfer to mul_start = 1 cycle; zero-bubble streaming at one word/cycle.

Reset
REQ-028 On rst, the block SHALL enter IDLE.
REQ-029 On rst, idx, n_words, mul_start, irq, busy, err and in_ready SHALL be 0.
REQ-030 On rst, all bank words SHALL be cleared to 0.
REQ-031 rst mid-transaction SHALL abort without mul_start or irq; a mul_done arriving afterwards SHALL be ignored.

Structure
REQ-032 A shared package mat_acc_pkg SHALL hold the state enum, the word typedef (logic [3:0][7:0]), and DEPTH/CNT_W defaults.
REQ-033 One sub-module, mat_bank (DEPTH-word register bank: write-enable, index, data, synchronous clear), SHALL be instantiated twice, once for A and once for B.

Verification
REQ-034 rst, cfg_words=4, go, stream 8 words with in_last on words 3 and 7 -> banks hold the data, mul_start pulse 1 cycle after word 7; mul_done 5 cycles later -> irq pulse, busy=0.
REQ-035 cfg_words=0 -> exactly 256 A transfers and 256 B transfers accepted before mul_start.
REQ-036 cfg_words=4, in_last on A word 1 -> err=1, IDLE, no mul_start; A[0..1] written, A[2..3] unchanged.
REQ-037 cfg_words=2, in_valid toggled every other cycle -> correct packing, no dropped or duplicate words, in_ready low in WAIT_DONE.
REQ-038 rst asserted during WAIT_DONE, then mul_done=1 -> no irq, all outputs at reset values.
REQ-039 go pulsed during LOAD_B and mul_done pulsed during LOAD_A -> no effect on state, counters or outputs.
